// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the tt_um_uart_tx tile: the transmitter state
// encoding, the data width and the uo_out bit positions.
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int DATA_BITS = 8;

    // uo_out bit positions
    localparam int TX_BIT   = 0;
    localparam int BUSY_BIT = 1;
    localparam int DONE_BIT = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

endpackage

// File: rtl/uart_tx_core.sv
// -----------------------------------------------------------------------------
// uart_tx_core
// Serialises one byte as 8N1 (or 8E1 when PARITY_EN=1). Every output is a
// flop, so there is no combinational path from start/data to tx/busy/done.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | line high, waiting for start
// ST_START  | start bit (tx=0) for CLKS_PER_BIT cycles
// ST_DATA   | 8 data bits, LSB first, CLKS_PER_BIT cycles each
// ST_PARITY | even-parity bit (only reachable when PARITY_EN=1)
// ST_STOP   | stop bit (tx=1); last cycle returns to IDLE and pulses done
//
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   start  in   accept request, honoured only in ST_IDLE
//   data   in   byte latched on the accept edge
//   tx     out  serial line
//   busy   out  high from the accept edge until the stop bit completes
//   done   out  one-cycle pulse on the edge busy falls
// -----------------------------------------------------------------------------
module uart_tx_core
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [DATA_BITS-1:0] data,
    output logic                 tx,
    output logic                 busy,
    output logic                 done
);

    localparam int                BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        IDX_LAST  = 3'(DATA_BITS - 1);

    tx_state_e              r_state;
    logic [BAUD_W-1:0]      r_baud;
    logic [2:0]             r_bit_idx;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_parity;
    logic                   r_tx;
    logic                   r_busy;
    logic                   r_done;

    tx_state_e              w_state_nxt;
    logic [BAUD_W-1:0]      w_baud_nxt;
    logic [2:0]             w_bit_idx_nxt;
    logic [DATA_BITS-1:0]   w_shift_nxt;
    logic                   w_parity_nxt;
    logic                   w_tx_nxt;
    logic                   w_busy_nxt;
    logic                   w_done_nxt;
    logic                   w_bit_end;

    assign w_bit_end = (r_baud == BAUD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_parity  <= 1'b0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_baud    <= w_baud_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_shift   <= w_shift_nxt;
            r_parity  <= w_parity_nxt;
            r_tx      <= w_tx_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
        end
    end

    // Next-state logic computes the value tx/busy/done must show after the
    // edge, so the registered outputs line up exactly with state changes.
    always_comb begin
        w_state_nxt   = r_state;
        w_baud_nxt    = r_baud;
        w_bit_idx_nxt = r_bit_idx;
        w_shift_nxt   = r_shift;
        w_parity_nxt  = r_parity;
        w_tx_nxt      = r_tx;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;

        if (r_state != ST_IDLE) begin
            w_baud_nxt = w_bit_end ? '0 : r_baud + 1'b1;
        end

        case (r_state)
            ST_IDLE: begin
                w_tx_nxt   = 1'b1;
                w_busy_nxt = 1'b0;
                w_baud_nxt = '0;
                if (start) begin
                    w_state_nxt   = ST_START;
                    w_shift_nxt   = data;
                    // parity is captured here because the shifter consumes the byte
                    w_parity_nxt  = ^data;
                    w_bit_idx_nxt = '0;
                    w_tx_nxt      = 1'b0;
                    w_busy_nxt    = 1'b1;
                end
            end
            ST_START: begin
                if (w_bit_end) begin
                    w_state_nxt = ST_DATA;
                    w_tx_nxt    = r_shift[0];
                end
            end
            ST_DATA: begin
                if (w_bit_end) begin
                    if (r_bit_idx == IDX_LAST) begin
                        if (PARITY_EN != 0) begin
                            w_state_nxt = ST_PARITY;
                            w_tx_nxt    = r_parity;
                        end else begin
                            w_state_nxt = ST_STOP;
                            w_tx_nxt    = 1'b1;
                        end
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                        w_shift_nxt   = {1'b0, r_shift[DATA_BITS-1:1]};
                        w_tx_nxt      = r_shift[1];
                    end
                end
            end
            ST_PARITY: begin
                if (w_bit_end) begin
                    w_state_nxt = ST_STOP;
                    w_tx_nxt    = 1'b1;
                end
            end
            ST_STOP: begin
                if (w_bit_end) begin
                    w_state_nxt = ST_IDLE;
                    w_tx_nxt    = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_tx_nxt    = 1'b1;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    assign tx   = r_tx;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: rtl/tt_um_uart_tx.sv
// -----------------------------------------------------------------------------
// tt_um_uart_tx
// Tiny Tapeout tile wrapper around uart_tx_core: gates the send request with
// ena and maps the transmitter onto the standard tile pins.
//
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   ena      in   tile enable; gates new requests only
//   ui_in    in   byte to transmit
//   uio_in   in   bit0 = send request (level), others unused
//   uo_out   out  bit0 tx, bit1 busy, bit2 done pulse, bits 7:3 zero
//   uio_out  out  tied 8'h00
//   uio_oe   out  tied 8'h00 (all uio pins are inputs)
// -----------------------------------------------------------------------------
module tt_um_uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic       w_start;
    logic       w_tx;
    logic       w_busy;
    logic       w_done;
    logic [7:0] w_uo;
    logic       w_unused;

    // ena only blocks new accepts; a frame in flight always completes.
    assign w_start  = ena & uio_in[0];
    assign w_unused = ^uio_in[7:1];

    uart_tx_core #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .PARITY_EN    (PARITY_EN)
    ) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .start (w_start),
        .data  (ui_in),
        .tx    (w_tx),
        .busy  (w_busy),
        .done  (w_done)
    );

    always_comb begin
        w_uo           = '0;
        w_uo[TX_BIT]   = w_tx;
        w_uo[BUSY_BIT] = w_busy;
        w_uo[DONE_BIT] = w_done;
    end

    assign uo_out  = w_uo;
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_uart_tx.sv
module tb_tt_um_uart_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic       req0, req1;
    logic [7:0] uio_in0, uio_in1;
    logic [7:0] uo0, uio_out0, uio_oe0;
    logic [7:0] uo1, uio_out1, uio_oe1;

    int n_checks = 0;
    int n_errors = 0;
    bit use_par  = 1'b0;

    logic tx_log   [0:127];
    logic busy_log [0:127];
    logic done_log [0:127];

    always #5 clk = ~clk;

    assign uio_in0 = {7'b0, req0};
    assign uio_in1 = {7'b0, req1};

    tt_um_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in0),
        .uo_out(uo0), .uio_out(uio_out0), .uio_oe(uio_oe0)
    );

    tt_um_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in1),
        .uo_out(uo1), .uio_out(uio_out1), .uio_oe(uio_oe1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected line state k cycles after the accept edge (4 clocks per bit).
    function automatic logic exp_tx(input logic [7:0] b, input bit par, input int k);
        int slot;
        int nb;
        slot = k / 4;
        nb   = par ? 11 : 10;
        if (k >= nb * 4) return 1'b1;
        if (slot == 0)   return 1'b0;
        if (slot <= 8)   return b[slot-1];
        if (par && slot == 9) return ^b;
        return 1'b1;
    endfunction

    task automatic start_req(input logic [7:0] b);
        @(negedge clk);
        ui_in = b;
        if (use_par) req1 = 1'b1; else req0 = 1'b1;
    endtask

    task automatic capture(input int n, input int req_off_at, input int ena_off_at,
                           input int ui_chg_at, input logic [7:0] ui_new, input bit scramble);
        logic [7:0] uo;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            uo = use_par ? uo1 : uo0;
            tx_log[i]   = uo[0];
            busy_log[i] = uo[1];
            done_log[i] = uo[2];
            if (i == req_off_at) begin req0 = 1'b0; req1 = 1'b0; end
            if (i == ena_off_at) ena = 1'b0;
            if (i == ui_chg_at)  ui_in = ui_new;
            if (scramble)        ui_in = 8'($urandom_range(0, 255));
        end
    endtask

    task automatic check_frame(input string tag, input int start, input logic [7:0] b,
                               input bit par, input int extra);
        int len, errs, busy_n, done_n, i;
        logic [7:0] rx;
        len = (par ? 11 : 10) * 4;
        errs = 0; busy_n = 0; done_n = 0; rx = '0;
        for (int k = 0; k <= len + extra; k++) begin
            i = start + k;
            if (tx_log[i]   !== exp_tx(b, par, k)) errs++;
            if (busy_log[i] !== (k < len))         errs++;
            if (done_log[i] !== (k == len))        errs++;
            if (busy_log[i] === 1'b1) busy_n++;
            if (done_log[i] === 1'b1) done_n++;
        end
        for (int j = 0; j < 8; j++) rx[j] = tx_log[start + 4 * (j + 1) + 2];
        check({tag, "_cycles"},   32'(errs),   32'd0);
        check({tag, "_byte"},     32'(rx),     32'(b));
        check({tag, "_busy_len"}, 32'(busy_n), 32'(len));
        check({tag, "_done_cnt"}, 32'(done_n), 32'd1);
    endtask

    initial begin
        logic [9:0] f;
        int cnt;

        rst_n = 1'b0; ena = 1'b1; ui_in = 8'h00; req0 = 1'b0; req1 = 1'b0;

        // reset state
        repeat (2) @(negedge clk);
        check("rst_uo0",      32'(uo0),      32'h01);
        check("rst_uio_out0", 32'(uio_out0), 32'h00);
        check("rst_uio_oe0",  32'(uio_oe0),  32'h00);
        check("rst_uo1",      32'(uo1),      32'h01);
        rst_n = 1'b1;
        @(negedge clk);

        // 8'hA5, 8N1
        start_req(8'hA5);
        capture(42, 0, -1, -1, 8'h00, 1'b0);
        check_frame("a5", 0, 8'hA5, 1'b0, 1);
        for (int k = 0; k < 10; k++) f[k] = tx_log[4 * k + 2];
        check("a5_bits", 32'(f), 32'(10'b1101001010));

        // even parity
        use_par = 1'b1;
        start_req(8'h07);
        capture(46, 0, -1, -1, 8'h00, 1'b0);
        check_frame("p07", 0, 8'h07, 1'b1, 1);
        check("p07_parity", 32'(tx_log[38]), 32'd1);
        start_req(8'h03);
        capture(46, 0, -1, -1, 8'h00, 1'b0);
        check_frame("p03", 0, 8'h03, 1'b1, 1);
        check("p03_parity", 32'(tx_log[38]), 32'd0);
        use_par = 1'b0;

        // back-to-back with request held high
        start_req(8'h55);
        capture(83, 41, -1, 2, 8'hFF, 1'b0);
        check_frame("b2b1", 0, 8'h55, 1'b0, 0);
        check_frame("b2b2", 41, 8'hFF, 1'b0, 1);
        cnt = 0;
        for (int i = 36; i < 83; i++) begin
            if (tx_log[i] !== 1'b1) break;
            cnt++;
        end
        check("b2b_gap", 32'(cnt), 32'd5);

        // ena gating
        @(negedge clk);
        ena = 1'b0; req0 = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (uo0[0] !== 1'b1 || uo0[1] !== 1'b0) cnt++;
        end
        check("gate_idle", 32'(cnt), 32'd0);
        req0 = 1'b0; ena = 1'b1;
        start_req(8'h3C);
        capture(42, 0, 10, -1, 8'h00, 1'b0);
        check_frame("ena_drop", 0, 8'h3C, 1'b0, 1);
        req0 = 1'b1;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (uo0[1] !== 1'b0) cnt++;
        end
        check("ena_blocked", 32'(cnt), 32'd0);
        req0 = 1'b0; ena = 1'b1;

        // ui_in churn during a frame
        start_req(8'h81);
        capture(42, 0, -1, -1, 8'h00, 1'b1);
        check_frame("stable", 0, 8'h81, 1'b0, 1);
        ui_in = 8'h00;

        // asynchronous reset mid-frame
        start_req(8'h00);
        capture(6, 0, -1, -1, 8'h00, 1'b0);
        check("pre_rst_tx", 32'(tx_log[5]), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_uo", 32'(uo0), 32'h01);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_uo", 32'(uo0), 32'h01);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tt_um_uart_tx.md
Name: tt_um_uart_tx

Overview:
Byte-wide UART transmitter in the standard Tiny Tapeout user-tile pinout. It serialises a parallel byte from ui_in onto a single TX pin as 8N1, or 8E1 when parity is enabled, with a request/busy handshake on the bidirectional and output pins. It is the transmit-side counterpart that drives the serial stimulus our tile benches consume.

Parameters:
CLKS_PER_BIT, 16, clock cycles per serial bit; legal range 2..255; bench uses 4
PARITY_EN, 0, 1 inserts an even-parity bit between data bit 7 and the stop bit

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
ena  input  1  tile enable; new requests are accepted only when 1
ui_in  input  8  byte to transmit, sampled on the accept edge
uio_in  input  8  bit0 = send request (level); bits 7:1 ignored
uo_out  output  8  bit0 = tx, bit1 = busy, bit2 = done pulse, bits 7:3 = 0
uio_out  output  8  constant 8'h00
uio_oe  output  8  constant 8'h00; all uio pins are inputs

Behaviour:
- Reset is asynchronous on rst_n low: state=IDLE, tx=1, busy=0, done=0, counters=0, shift reg=0. Outputs take these values immediately, without waiting for a clock edge.
- All outputs are registered, with no combinational input-to-output paths.
- FSM states: IDLE, START, DATA, PARITY (present only when PARITY_EN=1), STOP.
- IDLE: tx=1, busy=0. An accept occurs on an edge where state==IDLE && ena && uio_in[0]. On accept: latch ui_in into the shift register, go to START, busy=1, and tx=0 from that edge.
- Each non-IDLE state holds for exactly CLKS_PER_BIT cycles, timed by a baud counter that runs 0..CLKS_PER_BIT-1.
- START: tx=0.
- DATA: 8 bits, LSB first, tracked by a 3-bit index 0..7. Advance to the next state after bit 7 completes.
- PARITY: tx = XOR of the latched byte (even parity).
- STOP: tx=1. On its final cycle, go to IDLE, busy=0, and done=1 for exactly one cycle, asserted on the same edge busy falls.
- Frame length from the accept edge to the busy-fall edge is 10*CLKS_PER_BIT cycles, or 11*CLKS_PER_BIT with parity.
- Back-to-back: if the request is still high in the IDLE cycle after STOP, it is accepted there. The line then shows the stop bit plus one extra idle cycle (CLKS_PER_BIT+1 high cycles) before the next start bit.
- Changes on ui_in during a frame have no effect; only the latched byte is sent.
- The request is level-sensitive and ignored while busy. No queueing: a request that drops before IDLE is lost.
- ena falling mid-frame: the current frame completes normally, and new accepts are blocked until ena=1.
- rst_n asserted mid-frame: the frame is aborted and tx returns to 1 asynchronously. The receiver sees a framing error; this is accepted behaviour.
- The baud counter width is $clog2(CLKS_PER_BIT) and it must not wrap beyond CLKS_PER_BIT-1.

Decomposition:
- Package uart_pkg holds:
  - the state enum typedef
  - the localparam DATA_BITS=8
  - the uo_out bit-index constants TX_BIT=0, BUSY_BIT=1, DONE_BIT=2
- Sub-module uart_tx_core holds the FSM, baud counter and shift register, with ports clk, rst_n, start, data[7:0], tx, busy, done.
- The top level does the pin mapping and ena gating.

Test Plan:
1. Reset: hold rst_n=0 for 2 cycles -> uo_out=8'h01, uio_out=8'h00, uio_oe=8'h00. Then pulse rst_n low mid-frame -> tx=1 immediately, without waiting for a clock edge.
2. Send 8'hA5 with CLKS_PER_BIT=4 and PARITY_EN=0, request held 1 cycle -> tx sequence per 4-cycle bit is 0,1,0,1,0,0,1,0,1,1. busy is high for exactly 40 cycles, and done pulses once, coinciding with busy's falling edge.
3. Parity: send 8'h07 with PARITY_EN=1 -> parity bit = 1 and frame = 44 cycles. Then send 8'h03 -> parity bit = 0.
4. Back-to-back: hold request high with ui_in=8'h55 then 8'hFF -> second start bit begins exactly 5 cycles of tx high after the first stop bit begins. Both bytes decode correctly.
5. Gating: request=1 with ena=0 -> no start bit for 20 cycles. Drop ena during a frame of 8'h3C -> the frame completes intact.
6. Data stability: change ui_in every cycle during a frame of 8'h81 -> the received byte is still 8'h81.
